// File: rtl/bk_serial_alu.sv
// Byte-serial ALU: loads two WIDTH-bit operands one byte per beat, computes on a
// Brent-Kung prefix adder, then streams the result back one byte per beat with flags.
module bk_serial_alu #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ACC_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op,
  input  logic       cin,
  input  logic [7:0] a_byte,
  input  logic [7:0] b_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       cout,
  output logic       ovf
);

  localparam int unsigned NB    = WIDTH / 8;
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned LVL   = $clog2(WIDTH);
  localparam int unsigned NSTG  = 2 * LVL;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_SEND} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, acc_q;
  logic [1:0]         op_q, op_d, op_eff;
  logic               cin_q, cin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               cout_q, cout_d, ovf_q, ovf_d;

  logic [WIDTH-1:0]   x_op, y_op, sum_w;
  logic               c0, cout_w, ovf_w;
  logic [WIDTH-1:0]   gs [NSTG];
  logic [WIDTH-1:0]   ps [NSTG];
  logic [WIDTH:0]     carry;

  // Bytes arrive LSB first, so each new byte enters at the top and older ones slide down.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic [7:0]       nxt);
    return (cur >> 8) | (WIDTH'(nxt) << (WIDTH - 8));
  endfunction

  // Span of the combine at each tree stage: up-sweep 1,2,4.. then down-sweep ..4,2,1.
  function automatic int unsigned stage_dist(input int unsigned s);
    return (s < LVL) ? (32'd1 << s) : (32'd1 << (NSTG - 2 - s));
  endfunction

  function automatic logic is_node(input int unsigned s, input int unsigned i);
    int unsigned d;
    d = stage_dist(s);
    if (s < LVL) return ((i + 1) % (2 * d)) == 0;
    return (((i + 1) % (2 * d)) == d) && (i >= 2 * d);
  endfunction

  always_comb begin
    op_eff = op_q;
    if (ACC_EN == 0 && op_q[1]) op_eff = OP_ADD;
  end

  // Operand routing into the adder.
  always_comb begin
    x_op = a_q;
    y_op = b_q;
    c0   = cin_q;
    case (op_eff)
      OP_SUB: begin
        y_op = ~b_q;
        c0   = 1'b1;
      end
      OP_ACC: begin
        x_op = acc_q;
        y_op = a_q;
      end
      default: ;
    endcase
  end

  // Brent-Kung prefix tree: stage 0 is bitwise g/p, last stage holds full-prefix g/p per bit.
  always_comb begin
    gs[0] = x_op & y_op;
    ps[0] = x_op ^ y_op;
    for (int unsigned s = 0; s < NSTG - 1; s++) begin
      gs[s+1] = gs[s];
      ps[s+1] = ps[s];
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (is_node(s, i)) begin
          gs[s+1][i] = gs[s][i] | (ps[s][i] & gs[s][i - stage_dist(s)]);
          ps[s+1][i] = ps[s][i] & ps[s][i - stage_dist(s)];
        end
      end
    end
    carry[0] = c0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry[i+1] = gs[NSTG-1][i] | (ps[NSTG-1][i] & c0);
    end
    sum_w  = ps[0] ^ carry[WIDTH-1:0];
    cout_w = carry[WIDTH];
    ovf_w  = (x_op[WIDTH-1] == y_op[WIDTH-1]) & (sum_w[WIDTH-1] != x_op[WIDTH-1]);
  end

  // Next-state and register updates.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cin_d       = cin_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          op_d  = op;
          cin_d = cin;
          a_d   = shift_in(a_q, a_byte);
          b_d   = shift_in(b_q, b_byte);
          cnt_d = CNT_W'(1);
          if (NB == 1) begin
            state_d    = S_CALC;
            in_ready_d = 1'b0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          a_d   = shift_in(a_q, a_byte);
          b_d   = shift_in(b_q, b_byte);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NB - 1)) begin
            state_d    = S_CALC;
            in_ready_d = 1'b0;
          end
        end
      end
      S_CALC: begin
        if (op_eff == OP_CLR) begin
          res_d  = '0;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
        end else begin
          res_d  = sum_w;
          cout_d = cout_w;
          ovf_d  = ovf_w;
        end
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_last_d  = (NB == 1);
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
          end else begin
            res_d      = res_q >> 8;
            cnt_d      = cnt_q + CNT_W'(1);
            out_last_d = (cnt_d == CNT_W'(NB - 1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cin_q       <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cin_q       <= cin_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Accumulator updates only at the CALC edge.
  if (ACC_EN != 0) begin : g_acc
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (state_q == S_CALC) begin
        if (op_eff == OP_CLR)      acc_q <= '0;
        else if (op_eff == OP_ACC) acc_q <= sum_w;
      end
    end
  end else begin : g_no_acc
    assign acc_q = '0;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_byte  = res_q[7:0];
  assign out_last  = out_last_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bk_serial_alu.sv
// Directed bench for bk_serial_alu at WIDTH 8, 16 and 32 sharing one clock and reset.
module tb_bk_serial_alu;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] op;
  logic       cin;
  logic [7:0] a_byte, b_byte;
  logic       out_ready;
  logic       iv8, iv16, iv32;
  logic       ir8, ir16, ir32, ov8, ov16, ov32, ol8, ol16, ol32;
  logic       co8, co16, co32, of8, of16, of32;
  logic [7:0] ob8, ob16, ob32;

  logic       m_in_ready, m_out_valid, m_out_last, m_cout, m_ovf;
  logic [7:0] m_out_byte;
  int         sel = 16;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  bk_serial_alu #(.WIDTH(8), .ACC_EN(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op), .cin(cin),
    .a_byte(a_byte), .b_byte(b_byte), .out_valid(ov8), .out_ready(out_ready),
    .out_byte(ob8), .out_last(ol8), .cout(co8), .ovf(of8));

  bk_serial_alu #(.WIDTH(16), .ACC_EN(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op), .cin(cin),
    .a_byte(a_byte), .b_byte(b_byte), .out_valid(ov16), .out_ready(out_ready),
    .out_byte(ob16), .out_last(ol16), .cout(co16), .ovf(of16));

  bk_serial_alu #(.WIDTH(32), .ACC_EN(1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op), .cin(cin),
    .a_byte(a_byte), .b_byte(b_byte), .out_valid(ov32), .out_ready(out_ready),
    .out_byte(ob32), .out_last(ol32), .cout(co32), .ovf(of32));

  always_comb begin
    case (sel)
      8: begin
        m_in_ready = ir8; m_out_valid = ov8; m_out_byte = ob8;
        m_out_last = ol8; m_cout = co8; m_ovf = of8;
      end
      32: begin
        m_in_ready = ir32; m_out_valid = ov32; m_out_byte = ob32;
        m_out_last = ol32; m_cout = co32; m_ovf = of32;
      end
      default: begin
        m_in_ready = ir16; m_out_valid = ov16; m_out_byte = ob16;
        m_out_last = ol16; m_cout = co16; m_ovf = of16;
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_iv(input logic v);
    iv8  = (sel == 8)  ? v : 1'b0;
    iv16 = (sel == 16) ? v : 1'b0;
    iv32 = (sel == 32) ? v : 1'b0;
  endtask

  // Drives one full transaction, collects the result bytes and flags.
  task automatic do_txn(input int w, input logic [1:0] opv, input logic cinv,
                        input logic [63:0] av, input logic [63:0] bv,
                        input int gap, input int stall,
                        output logic [63:0] r, output logic co, output logic ov,
                        output int lat, output int wc);
    int nb;
    logic [7:0] hb;
    logic hl, hc, ho;
    nb  = w / 8;
    sel = w;
    r   = '0;
    co  = 1'b0;
    ov  = 1'b0;
    #1;
    wc = 0;
    while (m_in_ready !== 1'b1 && wc < 50) begin tick(); wc++; end
    if (m_in_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout w=%0d in_ready=%b required 1", w, m_in_ready);
    end
    for (int k = 0; k < nb; k++) begin
      if (k > 0 && gap > 0) begin
        set_iv(1'b0);
        a_byte = 8'hEE; b_byte = 8'hEE;
        repeat (gap) tick();
      end
      set_iv(1'b1);
      op     = (k == 0) ? opv : ~opv;
      cin    = (k == 0) ? cinv : ~cinv;
      a_byte = av[8*k +: 8];
      b_byte = bv[8*k +: 8];
      tick();
    end
    a_byte = 8'hA5; b_byte = 8'h5A;
    lat = 0;
    while (m_out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
    for (int k = 0; k < nb; k++) begin
      if (k == 0 && stall > 0) begin
        out_ready = 1'b0;
        hb = m_out_byte; hl = m_out_last; hc = m_cout; ho = m_ovf;
        for (int s = 0; s < stall; s++) begin
          tick();
          n_checks++;
          if ({m_out_valid, m_in_ready, m_out_byte, m_out_last, m_cout, m_ovf} !==
              {1'b1, 1'b0, hb, hl, hc, ho}) begin
            n_fail++;
            $display("FAIL stall_hold cyc=%0d got v=%b rdy=%b byte=%h last=%b c=%b o=%b required v=1 rdy=0 byte=%h last=%b c=%b o=%b",
                     s, m_out_valid, m_in_ready, m_out_byte, m_out_last, m_cout, m_ovf, hb, hl, hc, ho);
          end
        end
        out_ready = 1'b1;
      end
      n_checks++;
      if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL send_handshake w=%0d byte%0d out_valid=%b in_ready=%b required 1/0",
                 w, k, m_out_valid, m_in_ready);
      end
      n_checks++;
      if (m_out_last !== (k == nb - 1)) begin
        n_fail++;
        $display("FAIL out_last w=%0d byte%0d got %b required %b", w, k, m_out_last, (k == nb - 1));
      end
      if (k == 0) begin
        co = m_cout;
        ov = m_ovf;
      end else begin
        n_checks++;
        if (m_cout !== co || m_ovf !== ov) begin
          n_fail++;
          $display("FAIL flags_stable w=%0d byte%0d got c=%b o=%b required c=%b o=%b",
                   w, k, m_cout, m_ovf, co, ov);
        end
      end
      r[8*k +: 8] = m_out_byte;
      if (k == nb - 1) set_iv(1'b0);
      tick();
    end
    set_iv(1'b0);
    n_checks++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL txn_end w=%0d out_valid=%b in_ready=%b required 0/1", w, m_out_valid, m_in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_iv(1'b0);
    iv8 = 1'b0; iv16 = 1'b0; iv32 = 1'b0;
    out_ready = 1'b1; op = OP_ADD; cin = 1'b0; a_byte = '0; b_byte = '0;
    repeat (2) tick();
    n_checks++;
    if ({ir8, ov8, ob8, ol8, co8, of8, ir16, ov16, ob16, ol16, co16, of16,
         ir32, ov32, ob32, ol32, co32, of32} !== '0) begin
      n_fail++;
      $display("FAIL reset_values got w8=%b%b%h%b%b%b w16=%b%b%h%b%b%b w32=%b%b%h%b%b%b required all zero",
               ir8, ov8, ob8, ol8, co8, of8, ir16, ov16, ob16, ol16, co16, of16,
               ir32, ov32, ob32, ol32, co32, of32);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ir16 !== 1'b0) begin
      n_fail++;
      $display("FAIL in_ready_before_edge got %b required 0", ir16);
    end
    tick();
    n_checks++;
    if ({ir8, ir16, ir32} !== 3'b111) begin
      n_fail++;
      $display("FAIL in_ready_after_edge got %b required 111", {ir8, ir16, ir32});
    end
  endtask

  task automatic test_add();
    logic [63:0] r; logic co, ov; int lat, wc;
    do_txn(16, OP_ADD, 1'b1, 64'h1234, 64'h0FCD, 0, 0, r, co, ov, lat, wc);
    n_checks++;
    if ({r, co, ov} !== {64'h2202, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add16 got r=%h c=%b o=%b required r=2202 c=0 o=0", r, co, ov);
    end
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL add16_latency got %0d cycles after last beat, required 1", lat);
    end
  endtask

  task automatic test_sub();
    logic [63:0] r; logic co, ov; int lat, wc;
    do_txn(16, OP_SUB, 1'b0, 64'h8000, 64'h0001, 0, 0, r, co, ov, lat, wc);
    n_checks++;
    if ({r, co, ov} !== {64'h7FFF, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sub16_a got r=%h c=%b o=%b required r=7fff c=1 o=1", r, co, ov);
    end
    do_txn(16, OP_SUB, 1'b1, 64'h0000, 64'h0001, 0, 0, r, co, ov, lat, wc);
    n_checks++;
    if ({r, co, ov} !== {64'hFFFF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub16_b got r=%h c=%b o=%b required r=ffff c=0 o=0", r, co, ov);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] r; logic co, ov; int lat, wc;
    do_txn(16, OP_ADD, 1'b0, 64'hFFFF, 64'h0001, 0, 0, r, co, ov, lat, wc);
    n_checks++;
    if ({r, co, ov} !== {64'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap16 got r=%h c=%b o=%b required r=0000 c=1 o=0", r, co, ov);
    end
  endtask

  task automatic test_acc();
    logic [63:0] r; logic co, ov; int lat, wc;
    logic [63:0] av [4] = '{64'h5555, 64'h7000, 64'h2000, 64'h7001};
    logic [1:0]  ops [4] = '{OP_CLR, OP_ACC, OP_ACC, OP_ACC};
    logic        cins [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [65:0] exp [4] = '{{64'h0000, 2'b00}, {64'h7000, 2'b00},
                             {64'h9000, 2'b01}, {64'h0002, 2'b10}};
    for (int t = 0; t < 4; t++) begin
      do_txn(16, ops[t], cins[t], av[t], 64'hFFFF, 0, 0, r, co, ov, lat, wc);
      n_checks++;
      if ({r, co, ov} !== exp[t]) begin
        n_fail++;
        $display("FAIL acc_step%0d got r=%h c=%b o=%b required r=%h c=%b o=%b",
                 t, r, co, ov, exp[t][65:2], exp[t][1], exp[t][0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] r; logic co, ov; int lat, wc;
    do_txn(16, OP_ADD, 1'b0, 64'h00FF, 64'h0101, 2, 3, r, co, ov, lat, wc);
    n_checks++;
    if ({r, co, ov} !== {64'h0200, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL backpressure got r=%h c=%b o=%b required r=0200 c=0 o=0", r, co, ov);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r; logic co, ov; int lat, wc;
    do_txn(16, OP_ADD, 1'b0, 64'h0102, 64'h0304, 0, 0, r, co, ov, lat, wc);
    n_checks++;
    if (r !== 64'h0406) begin
      n_fail++;
      $display("FAIL b2b_first got r=%h required 0406", r);
    end
    do_txn(16, OP_ADD, 1'b0, 64'h7FFF, 64'h0001, 0, 0, r, co, ov, lat, wc);
    n_checks++;
    if ({r, co, ov, wc} !== {64'h8000, 1'b0, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL b2b_second got r=%h c=%b o=%b wait=%0d required r=8000 c=0 o=1 wait=0",
               r, co, ov, wc);
    end
  endtask

  // Checks reset outputs, then that ACC was cleared and a fresh ADD works.
  task automatic after_reset(input string tag);
    logic [63:0] r; logic co, ov; int lat, wc;
    n_checks++;
    if ({ir16, ov16, ob16, ol16, co16, of16} !== '0) begin
      n_fail++;
      $display("FAIL %s_outputs got rdy=%b v=%b byte=%h last=%b c=%b o=%b required all 0",
               tag, ir16, ov16, ob16, ol16, co16, of16);
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_txn(16, OP_ACC, 1'b0, 64'h0000, 64'h0000, 0, 0, r, co, ov, lat, wc);
    n_checks++;
    if (r !== 64'h0000) begin
      n_fail++;
      $display("FAIL %s_acc_cleared got %h required 0000", tag, r);
    end
    do_txn(16, OP_ADD, 1'b0, 64'h0001, 64'h0001, 0, 0, r, co, ov, lat, wc);
    n_checks++;
    if ({r, co, ov} !== {64'h0002, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_add got r=%h c=%b o=%b required r=0002 c=0 o=0", tag, r, co, ov);
    end
  endtask

  task automatic test_reset_mid_load();
    sel = 16;
    #1;
    set_iv(1'b1);
    op = OP_ADD; cin = 1'b1; a_byte = 8'h55; b_byte = 8'h55;
    tick();
    set_iv(1'b0);
    rst_n = 1'b0;
    #1;
    after_reset("rst_load");
  endtask

  task automatic test_reset_mid_send();
    logic [63:0] r; logic co, ov; int lat, wc;
    int n;
    do_txn(16, OP_ACC, 1'b0, 64'h0005, 64'h0000, 0, 0, r, co, ov, lat, wc);
    n_checks++;
    if (r !== 64'h0005) begin
      n_fail++;
      $display("FAIL rst_send_acc_setup got %h required 0005", r);
    end
    sel = 16;
    #1;
    for (int k = 0; k < 2; k++) begin
      set_iv(1'b1);
      op = OP_SUB; cin = 1'b0;
      a_byte = (k == 0) ? 8'h00 : 8'h80;
      b_byte = (k == 0) ? 8'h01 : 8'h00;
      tick();
    end
    set_iv(1'b0);
    out_ready = 1'b0;
    n = 0;
    while (ov16 !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    n_checks++;
    if ({ov16, ob16, co16, of16} !== {1'b1, 8'hFF, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_send_pre got v=%b byte=%h c=%b o=%b required v=1 byte=ff c=1 o=1",
               ov16, ob16, co16, of16);
    end
    rst_n = 1'b0;
    #1;
    out_ready = 1'b1;
    after_reset("rst_send");
  endtask

  task automatic test_widths();
    logic [63:0] r; logic co, ov; int lat, wc;
    int          ws [6] = '{8, 8, 8, 32, 32, 32};
    logic [63:0] av [6] = '{64'h12, 64'hFF, 64'h7F, 64'h12345678, 64'hFFFFFFFF, 64'h7FFFFFFF};
    logic [63:0] bv [6] = '{64'h0F, 64'h01, 64'h01, 64'h0FEDCBA9, 64'h00000001, 64'h00000001};
    logic        cv [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [65:0] exp [6] = '{{64'h22, 2'b00}, {64'h00, 2'b10}, {64'h80, 2'b01},
                             {64'h22222222, 2'b00}, {64'h00000000, 2'b10},
                             {64'h80000000, 2'b01}};
    for (int t = 0; t < 6; t++) begin
      do_txn(ws[t], OP_ADD, cv[t], av[t], bv[t], 0, 0, r, co, ov, lat, wc);
      n_checks++;
      if ({r, co, ov} !== exp[t]) begin
        n_fail++;
        $display("FAIL width%0d_case%0d got r=%h c=%b o=%b required r=%h c=%b o=%b",
                 ws[t], t, r, co, ov, exp[t][65:2], exp[t][1], exp[t][0]);
      end
      n_checks++;
      if (lat !== 1) begin
        n_fail++;
        $display("FAIL width%0d_latency got %0d required 1", ws[t], lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_wrap();
    test_acc();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_load();
    test_reset_mid_send();
    test_widths();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
